grey_tag_rx: RTL and testbench
==============================

Name: grey_tag_rx

Overview:
Fast-domain (250 MHz) receiver for the grey-code tagged byte transfer. The 125 MHz MAC-side tagger drives a registered word {tag, byte}; each new byte carries the next grey code, and the tag is gray(0) out of reset. This block synchronises that word, detects each new tag, checks sequence continuity and delivers bytes with valid/error strobes. A lock state machine supports loss-of-lock and recovery, and the block keeps error statistics for the book-building pipeline.

Parameters:
GREY_WIDTH, 8, width of the grey tag; the tag is bits [GREY_WIDTH+7:8] of tagDataIn.
LOCK_CNT, 4, consecutive in-sequence words needed to regain lock in HUNT (1..15).
UNLOCK_CNT, 2, consecutive out-of-sequence words in LOCKED that force HUNT (1..15).
ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
clkIn  in  1  250 MHz clock; the only clock in the block.
rstIn  in  1  asynchronous, active-high reset.
tagDataIn  in  GREY_WIDTH+8  {grey tag, byte} from the 125 MHz domain; asynchronous to clkIn.
rdDataOut  out  8  delivered byte.
rdDataValidOut  out  1  1-cycle strobe: in-sequence byte on rdDataOut.
rdDataErrOut  out  1  1-cycle strobe: out-of-sequence word detected while LOCKED.
lockedOut  out  1  high in the LOCKED state.
errCntOut  out  ERR_CNT_WIDTH  saturating count of rdDataErrOut pulses.

Behaviour:
- Reset values: rdDataOut=0, rdDataValidOut=0, rdDataErrOut=0, lockedOut=1, errCntOut=0. All sync stages=0, lastBin=0, badRun=0, goodRun=0, state=LOCKED. The reset state matches the transmitter reset, so the first word (tag gray(1)) is delivered.
- Capture pipeline, all edges on clkIn:
  - S1.tag <= tag in; S1.data is unused (0).
  - S2 <= {S1.tag, byte in}. The byte is sampled one cycle after the tag to let it settle.
  - S3 <= S2.
- newTag = (S3.tag != S2.tag). newTagR <= newTag.
- When newTagR=1, evaluate S3: rxBin = grey2bin(S3.tag); good = (rxBin == lastBin+1 mod 2^GREY_WIDTH). lastBin <= rxBin, always (resync on error).
- Latency: outputs are registered. A strobe asserts 3 cycles after the edge at which S1 first holds the new tag and lasts exactly 1 cycle. rdDataOut holds its value until the next evaluated word.
- State LOCKED:
  - good: rdDataValidOut=1, rdDataOut=S3.data, badRun<=0.
  - bad: rdDataErrOut=1, rdDataOut=S3.data, valid=0, errCnt+1 (saturates at all-ones), badRun+1.
  - When badRun+1 == UNLOCK_CNT: go to HUNT, goodRun<=0, lockedOut<=0.
- State HUNT:
  - No valid or err strobes; bytes are discarded.
  - good: goodRun+1; when goodRun+1 == LOCK_CNT, go to LOCKED, badRun<=0, lockedOut<=1. The locking word itself is not delivered.
  - bad: goodRun<=0.
- Wrap-around: rxBin 2^GREY_WIDTH-1 followed by 0 counts as good.
- A repeated identical tag produces no newTag, so no evaluation occurs.
- Back-to-back tag changes at 1-cycle spacing are outside the contract: the clock ratio must be >=2x, so words arrive at least 2 clkIn cycles apart. No error is flagged for this case.
- Reset asserted mid-stream clears all state immediately (asynchronous). The first post-reset word is judged against lastBin=0.
- Strobes: valid and err are never high in the same cycle.

Decomposition:
- Package cdc_pkg:
  - function grey2bin(logic [GREY_WIDTH-1:0]) and bin2grey, parameterised via a width parameter or a max-width variant.
  - typedef enum logic {LOCKED, HUNT} lock_state_t.
- Sub-module grey_tag_sync: holds S1/S2/S3, newTag and newTagR. It outputs the S3 word plus an evaluate strobe, and carries the ASYNC_REG attributes on S1/S2.
- The top module holds the lock FSM, run counters, error counter and output registers.

Test Plan:
1. Reset, then drive tags gray(1..5) with bytes 0x11..0x55, 8 clkIn apart -> 5 valid pulses with data 0x11..0x55; no err; lockedOut=1; errCntOut=0.
2. After tag gray(5), drive gray(7) with byte 0xAA -> one rdDataErrOut pulse with rdDataOut=0xAA and no valid; errCntOut=1. Next drive gray(8) with 0xBB -> valid with 0xBB.
3. Two consecutive skipped tags (UNLOCK_CNT=2) -> 2 err pulses; lockedOut falls after the 2nd. Then 4 in-sequence words -> lockedOut rises after the 4th with no valid pulses. The 5th word is valid.
4. Wrap: sequence bin 254,255,0,1 (gray 0x81,0x80,0x00,0x01) -> 4 valid pulses, no err.
5. Latency: a tag changes just before edge k -> rdDataValidOut high for exactly 1 cycle after edge k+3. Sweep the input change phase over 8 offsets -> latency always 3 or 4 cycles.
6. Assert rstIn asynchronously mid-word -> outputs go to reset values without waiting for clkIn. After release, gray(1) is accepted as valid. Force errCnt to all-ones, inject an error -> errCntOut stays all-ones.

Source files
------------

// File: rtl/grey_tag_rx_pkg.sv
// Shared types and grey/binary conversion helpers for the grey-tagged byte receiver.
// Helpers work on a 32-bit maximum width; narrower tags are zero-extended by the caller.
`timescale 1ns/1ps
package cdc_pkg;

  localparam int MAX_GREY_W = 32;

  typedef enum logic {LOCKED = 1'b0, HUNT = 1'b1} lock_state_t;

  function automatic logic [MAX_GREY_W-1:0] grey2bin(input logic [MAX_GREY_W-1:0] g);
    logic [MAX_GREY_W-1:0] b;
    b[MAX_GREY_W-1] = g[MAX_GREY_W-1];
    for (int i = MAX_GREY_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [MAX_GREY_W-1:0] bin2grey(input logic [MAX_GREY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/grey_tag_rx_sync.sv
// Brings the {tag, byte} word into clkIn and flags each new tag once it is stable in S3.
// The byte is captured one stage after the tag so it has settled by the time the tag moves.
`timescale 1ns/1ps
module grey_tag_sync
  import cdc_pkg::*;
#(
  parameter int GREY_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [GREY_WIDTH+7:0] i_tag_data,
  output logic [GREY_WIDTH-1:0] o_tag,
  output logic [7:0]            o_data,
  output logic                  o_eval
);

  (* ASYNC_REG = "TRUE" *) logic [GREY_WIDTH-1:0] r_s1_tag;
  (* ASYNC_REG = "TRUE" *) logic [GREY_WIDTH-1:0] r_s2_tag;
  (* ASYNC_REG = "TRUE" *) logic [7:0]            r_s2_data;
  logic [GREY_WIDTH-1:0] r_s3_tag;
  logic [7:0]            r_s3_data;
  logic                  r_new_tag;
  logic                  w_new_tag;

  assign w_new_tag = (r_s3_tag != r_s2_tag);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_tag  <= '0;
      r_s2_tag  <= '0;
      r_s2_data <= '0;
      r_s3_tag  <= '0;
      r_s3_data <= '0;
      r_new_tag <= 1'b0;
    end else begin
      r_s1_tag  <= i_tag_data[GREY_WIDTH+7:8];
      r_s2_tag  <= r_s1_tag;
      r_s2_data <= i_tag_data[7:0];
      r_s3_tag  <= r_s2_tag;
      r_s3_data <= r_s2_data;
      r_new_tag <= w_new_tag;
    end
  end

  assign o_tag  = r_s3_tag;
  assign o_data = r_s3_data;
  assign o_eval = r_new_tag;

endmodule

// File: rtl/grey_tag_rx.sv
// Grey-tagged byte receiver: sequence check, lock/hunt FSM, registered strobes and
// a saturating error counter. Reset state mirrors the transmitter reset (tag gray(0)).
`timescale 1ns/1ps
module grey_tag_rx
  import cdc_pkg::*;
#(
  parameter int GREY_WIDTH    = 8,
  parameter int LOCK_CNT      = 4,
  parameter int UNLOCK_CNT    = 2,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clkIn,
  input  logic                     rstIn,
  input  logic [GREY_WIDTH+7:0]    tagDataIn,
  output logic [7:0]               rdDataOut,
  output logic                     rdDataValidOut,
  output logic                     rdDataErrOut,
  output logic                     lockedOut,
  output logic [ERR_CNT_WIDTH-1:0] errCntOut
);

  logic [GREY_WIDTH-1:0]    w_tag;
  logic [7:0]               w_data;
  logic                     w_eval;
  logic [GREY_WIDTH-1:0]    w_rx_bin;
  logic                     w_good;

  lock_state_t              r_state;
  logic [GREY_WIDTH-1:0]    r_last_bin;
  logic [3:0]               r_bad_run;
  logic [3:0]               r_good_run;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
  logic [7:0]               r_data;
  logic                     r_valid;
  logic                     r_err;
  logic                     r_locked;

  grey_tag_sync #(.GREY_WIDTH(GREY_WIDTH)) u_sync (
    .i_clk      (clkIn),
    .i_rst      (rstIn),
    .i_tag_data (tagDataIn),
    .o_tag      (w_tag),
    .o_data     (w_data),
    .o_eval     (w_eval)
  );

  // Modular compare makes the all-ones -> zero wrap count as in sequence.
  assign w_rx_bin = GREY_WIDTH'(grey2bin(MAX_GREY_W'(w_tag)));
  assign w_good   = (w_rx_bin == GREY_WIDTH'(r_last_bin + 1'b1));

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_state    <= LOCKED;
      r_last_bin <= '0;
      r_bad_run  <= '0;
      r_good_run <= '0;
      r_err_cnt  <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_locked   <= 1'b1;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_eval) begin
        r_last_bin <= w_rx_bin;
        case (r_state)
          LOCKED: begin
            r_data <= w_data;
            if (w_good) begin
              r_valid   <= 1'b1;
              r_bad_run <= '0;
            end else begin
              r_err <= 1'b1;
              if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
              r_bad_run <= r_bad_run + 4'd1;
              if (r_bad_run + 4'd1 == 4'(UNLOCK_CNT)) begin
                r_state    <= HUNT;
                r_good_run <= '0;
                r_locked   <= 1'b0;
              end
            end
          end
          HUNT: begin
            // Bytes are discarded here; the word that completes the lock run is not delivered.
            if (w_good) begin
              r_good_run <= r_good_run + 4'd1;
              if (r_good_run + 4'd1 == 4'(LOCK_CNT)) begin
                r_state   <= LOCKED;
                r_bad_run <= '0;
                r_locked  <= 1'b1;
              end
            end else begin
              r_good_run <= '0;
            end
          end
          default: r_state <= LOCKED;
        endcase
      end
    end
  end

  assign rdDataOut      = r_data;
  assign rdDataValidOut = r_valid;
  assign rdDataErrOut   = r_err;
  assign lockedOut      = r_locked;
  assign errCntOut      = r_err_cnt;

endmodule

// File: tb/tb_grey_tag_rx.sv
// Directed bench for grey_tag_rx: sequencing, lock/hunt, wrap, latency sweep, async reset, saturation.
`timescale 1ns/1ps
module tb_grey_tag_rx;

  localparam int ECW = 3;

  logic           clkIn = 1'b0;
  logic           rstIn;
  logic [15:0]    tagDataIn;
  logic [7:0]     rdDataOut;
  logic           rdDataValidOut;
  logic           rdDataErrOut;
  logic           lockedOut;
  logic [ECW-1:0] errCntOut;

  int vectors = 0;
  int miscompares = 0;
  int n_valid = 0;
  int n_err = 0;
  int both_seen = 0;
  logic [7:0] last_vdata = 8'h00;
  int bin;
  int exp_v;
  int exp_e;

  grey_tag_rx #(
    .GREY_WIDTH(8), .LOCK_CNT(4), .UNLOCK_CNT(2), .ERR_CNT_WIDTH(ECW)
  ) dut (
    .clkIn          (clkIn),
    .rstIn          (rstIn),
    .tagDataIn      (tagDataIn),
    .rdDataOut      (rdDataOut),
    .rdDataValidOut (rdDataValidOut),
    .rdDataErrOut   (rdDataErrOut),
    .lockedOut      (lockedOut),
    .errCntOut      (errCntOut)
  );

  always #2 clkIn = ~clkIn;

  always @(negedge clkIn) begin
    if (rdDataValidOut) begin
      n_valid++;
      last_vdata = rdDataOut;
    end
    if (rdDataErrOut) n_err++;
    if (rdDataValidOut && rdDataErrOut) both_seen++;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] gray(input int b);
    logic [7:0] v;
    v = b[7:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int b, input logic [7:0] d);
    @(posedge clkIn);
    #1 tagDataIn = {gray(b), d};
    repeat (8) @(negedge clkIn);
  endtask

  initial begin
    rstIn = 1'b1;
    tagDataIn = '0;
    repeat (3) @(posedge clkIn);
    #1;
    chk("rst_data", rdDataOut, 0);
    chk("rst_valid", rdDataValidOut, 0);
    chk("rst_err", rdDataErrOut, 0);
    chk("rst_locked", lockedOut, 1);
    chk("rst_errcnt", errCntOut, 0);
    @(negedge clkIn) rstIn = 1'b0;
    repeat (3) @(negedge clkIn);

    // 1: in-sequence words 1..5
    for (int i = 1; i <= 5; i++) begin
      send(i, 8'(i * 8'h11));
      chk("t1_nvalid", n_valid, i);
      chk("t1_data", last_vdata, 8'(i * 8'h11));
    end
    chk("t1_nerr", n_err, 0);
    chk("t1_locked", lockedOut, 1);
    chk("t1_errcnt", errCntOut, 0);

    // 2: skip one tag, then recover
    send(7, 8'hAA);
    chk("t2_nerr", n_err, 1);
    chk("t2_errdata", rdDataOut, 8'hAA);
    chk("t2_novalid", n_valid, 5);
    chk("t2_errcnt", errCntOut, 1);
    send(8, 8'hBB);
    chk("t2_nvalid", n_valid, 6);
    chk("t2_data", last_vdata, 8'hBB);

    // 3: two bad words drop lock, four good words regain it
    send(10, 8'hC1);
    chk("t3_locked_after1", lockedOut, 1);
    send(12, 8'hCC);
    chk("t3_nerr", n_err, 3);
    chk("t3_unlocked", lockedOut, 0);
    chk("t3_errcnt", errCntOut, 3);
    for (int i = 13; i <= 16; i++) begin
      send(i, 8'h40 + 8'(i));
      chk("t3_hunt_lock", lockedOut, (i == 16) ? 1 : 0);
    end
    chk("t3_hunt_novalid", n_valid, 6);
    chk("t3_hunt_data_held", rdDataOut, 8'hCC);
    send(17, 8'h77);
    chk("t3_nvalid", n_valid, 7);
    chk("t3_data", last_vdata, 8'h77);

    // 4: wrap-around 254,255,0,1 (set up lastBin=253 with one error)
    send(253, 8'h01);
    chk("t4_setup_err", n_err, 4);
    send(254, 8'hE0);
    send(255, 8'hE1);
    send(0, 8'hE2);
    chk("t4_wrap_data", last_vdata, 8'hE2);
    send(1, 8'hE3);
    chk("t4_nvalid", n_valid, 11);
    chk("t4_nerr", n_err, 4);
    chk("t4_locked", lockedOut, 1);

    // 5: latency sweep over 8 input phases
    bin = 1;
    for (int off = 0; off < 8; off++) begin
      int n;
      n = 0;
      @(posedge clkIn);
      #(0.25 + 0.5 * off);
      bin++;
      tagDataIn = {gray(bin), 8'h60 + 8'(off)};
      while (n < 10) begin
        @(posedge clkIn);
        n++;
        #1;
        if (rdDataValidOut) break;
      end
      chk("t5_latency", n, 4);
      @(posedge clkIn);
      #1;
      chk("t5_strobe_width", rdDataValidOut, 0);
      repeat (4) @(posedge clkIn);
    end
    repeat (2) @(negedge clkIn);
    chk("t5_nvalid", n_valid, 19);
    chk("t5_lastdata", last_vdata, 8'h67);

    // 6: async reset mid-word from HUNT with nonzero state
    send(20, 8'hD1);
    send(30, 8'hD0);
    chk("t6_pre_locked", lockedOut, 0);
    chk("t6_pre_errcnt", errCntOut, 6);
    @(posedge clkIn);
    #1 rstIn = 1'b1;
    tagDataIn = '0;
    #0.5;
    chk("t6_async_data", rdDataOut, 0);
    chk("t6_async_locked", lockedOut, 1);
    chk("t6_async_errcnt", errCntOut, 0);
    chk("t6_async_err", rdDataErrOut, 0);
    repeat (2) @(negedge clkIn);
    rstIn = 1'b0;
    repeat (3) @(negedge clkIn);
    exp_v = n_valid + 1;
    send(1, 8'hE1);
    chk("t6_post_nvalid", n_valid, exp_v);
    chk("t6_post_data", last_vdata, 8'hE1);

    // Saturation: alternate bad/good so lock is kept while errors accumulate
    bin = 1;
    exp_e = 0;
    for (int i = 0; i < 8; i++) begin
      bin += 2;
      send(bin, 8'h90 + 8'(i));
      exp_e = (exp_e < 7) ? exp_e + 1 : 7;
      chk("t6_sat_errcnt", errCntOut, exp_e);
      bin += 1;
      send(bin, 8'hA0 + 8'(i));
    end
    chk("t6_sat_locked", lockedOut, 1);
    chk("no_valid_and_err", both_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
